// File: rtl/stream_demux_pkg.sv
// Shared definitions for the stream demultiplexer: FSM state encoding and a
// ceiling-log2 helper used to validate the select width at elaboration.
package stream_demux_pkg;

    // IDLE: nothing pending. HOLD: at least one channel still owes a handshake.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    // Smallest r such that 2**r >= value (0 for value <= 1).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/stream_demux_onehot_dec.sv
// Combinational select decoder: turns a binary channel index into a one-hot
// channel mask and flags whether the index names a channel that exists.
module demux_onehot_dec
    import stream_demux_pkg::*;
#(
    parameter int SEL_W  = 3,
    parameter int NUM_CH = 8
) (
    input  logic [SEL_W-1:0]  sel,
    output logic [NUM_CH-1:0] onehot,
    output logic              in_range
);

    // Decode sel; indices at or above NUM_CH produce an all-zero mask.
    always_comb begin
        onehot   = '0;
        in_range = (int'(sel) < NUM_CH);
        for (int i = 0; i < NUM_CH; i++) begin
            onehot[i] = (int'(sel) == i);
        end
    end

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-NUM_CH stream demultiplexer. One word is held at a time;
// a pending mask tracks which channels still have to take it. Unicast loads a
// one-hot mask, broadcast loads all ones, out-of-range selects are swallowed
// and counted in a saturating drop counter.
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 8,
    parameter int SEL_W  = 3,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [SEL_W-1:0]  in_sel,
    input  logic              in_bcast,
    output logic [NUM_CH-1:0] out_valid,
    input  logic [NUM_CH-1:0] out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  drop_cnt
);

    if (NUM_CH < 2 || NUM_CH > 32 || SEL_W < clog2(NUM_CH)) begin : g_param_check
        $error("stream_demux: NUM_CH must be 2..32 and SEL_W >= clog2(NUM_CH)");
    end

    state_e              state_q, state_d;
    logic [NUM_CH-1:0]   pend_q, pend_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [CNT_W-1:0]    drop_q, drop_d;

    logic [NUM_CH-1:0]   sel_onehot;
    logic                sel_in_range;
    logic [NUM_CH-1:0]   pend_left;
    logic                accept;

    demux_onehot_dec #(
        .SEL_W  (SEL_W),
        .NUM_CH (NUM_CH)
    ) u_dec (
        .sel      (in_sel),
        .onehot   (sel_onehot),
        .in_range (sel_in_range)
    );

    // Channels still owing a handshake after this cycle; when none remain the
    // slot frees up in the same cycle, giving bubble-free back-to-back words.
    always_comb begin
        pend_left = pend_q & ~out_ready;
        in_ready  = (state_q == ST_IDLE) || (pend_left == '0);
        accept    = in_valid && in_ready;
    end

    // Next-state logic: retire handshakes, then load a new word on accept.
    always_comb begin
        pend_d  = pend_left;
        data_d  = data_q;
        drop_d  = drop_q;
        state_d = state_q;
        if (accept) begin
            if (in_bcast) begin
                pend_d = '1;
                data_d = in_data;
            end else if (sel_in_range) begin
                pend_d = sel_onehot;
                data_d = in_data;
            end else begin
                pend_d = '0;
                if (drop_q != {CNT_W{1'b1}}) begin
                    drop_d = drop_q + 1'b1;
                end
            end
        end
        state_d = (pend_d != '0) ? ST_HOLD : ST_IDLE;
    end

    // State, pending mask, held word and drop counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            data_q  <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            data_q  <= data_d;
            drop_q  <= drop_d;
        end
    end

    assign out_valid = pend_q;
    assign out_data  = data_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_stream_demux.sv
// Directed, self-checking bench for stream_demux. An 8-channel instance covers
// unicast, backpressure, broadcast, streaming and mid-transfer reset; a
// 6-channel instance with a 2-bit counter covers dropped selects.
module tb_stream_demux;

    // Expected word on an 8-channel output: which channel and which data.
    typedef struct packed {
        logic [7:0] mask;
        logic [7:0] data;
    } exp_entry_t;

    logic       clk;
    logic       rst;

    logic       inValid;
    logic       inReady;
    logic [7:0] inData;
    logic [2:0] inSel;
    logic       inBcast;
    logic [7:0] outValid;
    logic [7:0] outReady;
    logic [7:0] outData;
    logic [7:0] dropCnt;

    logic       inValid6;
    logic       inReady6;
    logic [7:0] inData6;
    logic [2:0] inSel6;
    logic       inBcast6;
    logic [5:0] outValid6;
    logic [5:0] outReady6;
    logic [7:0] outData6;
    logic [1:0] dropCnt6;

    int         checks;
    int         errors;
    exp_entry_t sbQ[$];
    logic [7:0] expVal;

    stream_demux #(
        .DATA_W (8),
        .NUM_CH (8),
        .SEL_W  (3),
        .CNT_W  (8)
    ) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .in_data   (inData),
        .in_sel    (inSel),
        .in_bcast  (inBcast),
        .out_valid (outValid),
        .out_ready (outReady),
        .out_data  (outData),
        .drop_cnt  (dropCnt)
    );

    stream_demux #(
        .DATA_W (8),
        .NUM_CH (6),
        .SEL_W  (3),
        .CNT_W  (2)
    ) u_dut6 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inValid6),
        .in_ready  (inReady6),
        .in_data   (inData6),
        .in_sel    (inSel6),
        .in_bcast  (inBcast6),
        .out_valid (outValid6),
        .out_ready (outReady6),
        .out_data  (outData6),
        .drop_cnt  (dropCnt6)
    );

    // Free-running 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison: count it, and report tag/observed/expected on failure.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Move to just after the next rising edge, where inputs are changed.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Drive the 8-channel producer interface.
    task automatic applyStimulus(input logic v, input logic [2:0] s,
                                 input logic [7:0] d, input logic b);
        inValid = v;
        inSel   = s;
        inData  = d;
        inBcast = b;
    endtask

    // Drive the 6-channel producer interface (unicast only).
    task automatic applyStimulus6(input logic v, input logic [2:0] s,
                                  input logic [7:0] d);
        inValid6 = v;
        inSel6   = s;
        inData6  = d;
        inBcast6 = 1'b0;
    endtask

    // When a handshake completes on the 8-channel outputs, pop the oldest
    // expected word and compare channel mask and data.
    task automatic scoreCheck(input string tag);
        exp_entry_t e;
        if ((outValid & outReady) != 8'h00) begin
            if (sbQ.size() == 0) begin
                checkOutput({tag, "_unexpected"}, 32'(outValid), 32'h0);
            end else begin
                e = sbQ.pop_front();
                checkOutput({tag, "_mask"}, 32'(outValid), 32'(e.mask));
                checkOutput({tag, "_data"}, 32'(outData), 32'(e.data));
            end
        end
    endtask

    // Linear sequence of directed steps; outputs are sampled on falling edges.
    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        outReady  = 8'h00;
        outReady6 = 6'h00;
        applyStimulus(1'b0, 3'd0, 8'h00, 1'b0);
        applyStimulus6(1'b0, 3'd0, 8'h00);

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_out_valid", 32'(outValid), 32'h0);
        checkOutput("rst_out_data", 32'(outData), 32'h0);
        checkOutput("rst_drop_cnt", 32'(dropCnt), 32'h0);
        checkOutput("rst_in_ready", 32'(inReady), 32'h1);
        checkOutput("rst6_out_valid", 32'(outValid6), 32'h0);
        checkOutput("rst6_in_ready", 32'(inReady6), 32'h1);

        // Unicast to channel 3 with all consumers ready.
        nextCycle();
        outReady = 8'hFF;
        applyStimulus(1'b1, 3'd3, 8'hA5, 1'b0);
        sbQ.push_back('{mask: 8'b0000_1000, data: 8'hA5});
        @(negedge clk);
        checkOutput("uni_in_ready", 32'(inReady), 32'h1);
        nextCycle();
        applyStimulus(1'b0, 3'd0, 8'h00, 1'b0);
        @(negedge clk);
        checkOutput("uni_out_valid", 32'(outValid), 32'h08);
        checkOutput("uni_out_data", 32'(outData), 32'hA5);
        scoreCheck("uni_sb");
        nextCycle();
        @(negedge clk);
        checkOutput("uni_done", 32'(outValid), 32'h0);

        // Backpressure on channel 5 for four cycles, then release.
        nextCycle();
        outReady = 8'hDF;
        applyStimulus(1'b1, 3'd5, 8'h3C, 1'b0);
        sbQ.push_back('{mask: 8'b0010_0000, data: 8'h3C});
        @(negedge clk);
        nextCycle();
        applyStimulus(1'b0, 3'd0, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput($sformatf("bp_hold_valid_%0d", i), 32'(outValid), 32'h20);
            checkOutput($sformatf("bp_hold_ready_%0d", i), 32'(inReady), 32'h0);
            checkOutput($sformatf("bp_hold_data_%0d", i), 32'(outData), 32'h3C);
            nextCycle();
        end
        outReady = 8'hFF;
        @(negedge clk);
        checkOutput("bp_release_ready", 32'(inReady), 32'h1);
        scoreCheck("bp_sb");
        nextCycle();
        @(negedge clk);
        checkOutput("bp_done", 32'(outValid), 32'h0);

        // Broadcast; consumers take the word one per cycle from 7 down to 0.
        nextCycle();
        outReady = 8'h00;
        applyStimulus(1'b1, 3'd2, 8'h77, 1'b1);
        @(negedge clk);
        nextCycle();
        applyStimulus(1'b0, 3'd0, 8'h00, 1'b0);
        @(negedge clk);
        checkOutput("bc_all_valid", 32'(outValid), 32'hFF);
        checkOutput("bc_all_ready", 32'(inReady), 32'h0);
        expVal = 8'hFF;
        for (int k = 7; k >= 0; k--) begin
            nextCycle();
            outReady[k] = 1'b1;
            @(negedge clk);
            checkOutput($sformatf("bc_valid_%0d", k), 32'(outValid), 32'(expVal));
            checkOutput($sformatf("bc_in_ready_%0d", k), 32'(inReady), (k == 0) ? 32'h1 : 32'h0);
            checkOutput($sformatf("bc_data_%0d", k), 32'(outData), 32'h77);
            expVal[k] = 1'b0;
        end
        nextCycle();
        @(negedge clk);
        checkOutput("bc_done", 32'(outValid), 32'h0);

        // Sixteen words round-robin over channels 0..7, one per cycle.
        outReady = 8'hFF;
        for (int i = 0; i < 16; i++) begin
            nextCycle();
            applyStimulus(1'b1, 3'(i % 8), 8'h10 + 8'(i), 1'b0);
            sbQ.push_back('{mask: 8'(1 << (i % 8)), data: 8'h10 + 8'(i)});
            @(negedge clk);
            checkOutput($sformatf("b2b_no_bubble_%0d", i), 32'(inReady), 32'h1);
            scoreCheck($sformatf("b2b_sb_%0d", i));
        end
        nextCycle();
        applyStimulus(1'b0, 3'd0, 8'h00, 1'b0);
        @(negedge clk);
        scoreCheck("b2b_sb_last");
        checkOutput("sb_empty", 32'(sbQ.size()), 32'h0);

        // Out-of-range selects on the 6-channel instance, with saturation.
        outReady6 = 6'h3F;
        nextCycle();
        applyStimulus6(1'b1, 3'd6, 8'h11);
        @(negedge clk);
        checkOutput("drop_in_ready", 32'(inReady6), 32'h1);
        nextCycle();
        applyStimulus6(1'b1, 3'd7, 8'h22);
        @(negedge clk);
        checkOutput("drop_cnt_1", 32'(dropCnt6), 32'h1);
        checkOutput("drop_valid_1", 32'(outValid6), 32'h0);
        nextCycle();
        applyStimulus6(1'b1, 3'd2, 8'h5A);
        @(negedge clk);
        checkOutput("drop_cnt_2", 32'(dropCnt6), 32'h2);
        checkOutput("drop_valid_2", 32'(outValid6), 32'h0);
        nextCycle();
        applyStimulus6(1'b1, 3'd6, 8'h33);
        @(negedge clk);
        checkOutput("drop_sel2_valid", 32'(outValid6), 32'h04);
        checkOutput("drop_sel2_data", 32'(outData6), 32'h5A);
        checkOutput("drop_sel2_cnt", 32'(dropCnt6), 32'h2);
        nextCycle();
        applyStimulus6(1'b1, 3'd7, 8'h44);
        @(negedge clk);
        checkOutput("drop_cnt_3", 32'(dropCnt6), 32'h3);
        checkOutput("drop_valid_3", 32'(outValid6), 32'h0);
        nextCycle();
        applyStimulus6(1'b1, 3'd6, 8'h55);
        @(negedge clk);
        checkOutput("drop_cnt_sat4", 32'(dropCnt6), 32'h3);
        nextCycle();
        applyStimulus6(1'b0, 3'd0, 8'h00);
        @(negedge clk);
        checkOutput("drop_cnt_sat5", 32'(dropCnt6), 32'h3);
        checkOutput("drop_valid_end", 32'(outValid6), 32'h0);

        // Reset while channel 4 is stalled; the held word must be lost.
        nextCycle();
        outReady = 8'h00;
        applyStimulus(1'b1, 3'd4, 8'h99, 1'b0);
        @(negedge clk);
        nextCycle();
        applyStimulus(1'b0, 3'd0, 8'h00, 1'b0);
        @(negedge clk);
        checkOutput("midrst_before_valid", 32'(outValid), 32'h10);
        checkOutput("midrst_before_ready", 32'(inReady), 32'h0);
        nextCycle();
        rst = 1'b1;
        nextCycle();
        @(negedge clk);
        checkOutput("midrst_valid", 32'(outValid), 32'h0);
        checkOutput("midrst_data", 32'(outData), 32'h0);
        checkOutput("midrst_drop_cnt", 32'(dropCnt), 32'h0);
        checkOutput("midrst_in_ready", 32'(inReady), 32'h1);
        checkOutput("midrst_drop_cnt6", 32'(dropCnt6), 32'h0);
        nextCycle();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_valid", 32'(outValid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
